pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised N-stage valid/allowin pipeline controller with payload registers. It generalises the per-stage handshake of the 5-stage core into a single reusable chain. Adds per-stage flush (kill), per-stage external ready-go stalls, an output handshake, occupancy reporting and retire/stall performance counters. It is the backbone for the next-generation core pipeline and for multi-cycle units.

Parameters:
NUM_STAGES, 4, number of stages (minimum 2); stage 0 is youngest, stage NUM_STAGES-1 is oldest.
DATA_W, 64, payload width per stage.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has an item
in_data  in  DATA_W  producer payload
in_allowin  out  1  stage 0 can accept; equals allowin[0]; forced 0 while reset is high
stage_readygo  in  NUM_STAGES  bit i: stage i's item has finished its work
flush  in  NUM_STAGES  bit i: kill stage i content and any item entering stage i this cycle
out_valid  out  1  oldest stage presents an item
out_data  out  DATA_W  payload of stage NUM_STAGES-1
out_ready  in  1  consumer accepts
stage_valid  out  NUM_STAGES  registered valid bits
stage_data  out  NUM_STAGES*DATA_W  payloads; stage i occupies bits [i*DATA_W +: DATA_W]
occupancy  out  $clog2(NUM_STAGES+1)  popcount of stage_valid
counter_clr  in  1  synchronous clear of both counters
retire_cnt  out  CNT_W  number of output transfers
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- go[i] = valid[i] & stage_readygo[i] & ~flush[i]. The upstream go of stage 0 is in_valid.
- out_valid = go[NUM_STAGES-1]. out_fire = out_valid & out_ready.
- allowin[i] = ~valid[i] | (stage_readygo[i] & allowin[i+1]). The downstream allowin of the last stage is out_ready.
- allowin is purely combinational and does not depend on flush. There is no path from flush to in_allowin.
- Valid update at each clock edge, in priority order:
  - reset: valid[i] <= 0.
  - flush[i]: valid[i] <= 0.
  - allowin[i]: valid[i] <= go[i-1] (in_valid for stage 0).
  - otherwise: hold.
- Data update: data[i] <= upstream data only when allowin[i] & go[i-1] & ~flush[i]; otherwise hold. Reset clears data to 0.
- A flushed item never advances and never appears at the output.
- When stage i-1 transfers into a flushed stage i, stage i-1 still empties and its item is discarded.
- Zero-bubble throughput: one item per cycle when all readygo and out_ready are 1.
- Latency: an item accepted at edge t is in stage k after edge t+k. It is visible on out_data/out_valid during the cycle after edge t+NUM_STAGES-1.
- A stalled stage (readygo=0) holds its item. Back-pressure propagates combinationally to all younger stages in the same cycle. Older stages drain independently.
- Ordering: items exit in acceptance order minus killed items. There is no duplication and no loss without a flush.
- Counters:
  - retire_cnt += out_fire; stall_cnt += (out_valid & ~out_ready).
  - Both wrap modulo 2^CNT_W.
  - counter_clr has priority over increment; a clear and an event in the same cycle gives 0.
  - Reset clears both counters.
- Reset values: stage_valid=0, out_valid=0, occupancy=0, stage_data=0, out_data=0, counters=0, in_allowin=0 during reset.
- Reset mid-operation discards all items with no output transfer. in_allowin=1 in the first cycle after reset deasserts.
- flush of all bits while full: occupancy=0 after the edge, and nothing is accepted that cycle.

Test Plan:
1. NUM_STAGES=4, DATA_W=32, all readygo=1, out_ready=1, feed 1..8 back-to-back -> out_data 1..8 on consecutive cycles; first out_valid appears 3 edges after the accept edge; retire_cnt=8; stall_cnt=0.
2. out_ready=0, feed 1..6 -> in_allowin drops after 4 accepts; occupancy=4; stall_cnt increments each cycle. Raise out_ready -> output is 1..6 in order with no gaps.
3. Pipeline full with 1..4 (stage0=4), stage_readygo[1]=0 for 3 cycles -> stages 0-1 hold 4,3; stages 2-3 drain 2,1; in_allowin=0 during the stall; order is preserved after release.
4. Full pipe 1..4, flush=4'b0011 for one cycle with out_ready=1 -> items 4 and 3 are dropped; output sequence is 1,2, then the next fed item; retire_cnt counts only the 2 surviving items.
5. Stage 1 holds item 5 moving into stage 2 while flush[2]=1 -> stage 1 empties, stage 2 valid=0, item 5 never retires.
6. Assert reset mid-stream with occupancy=3 and counters nonzero -> all outputs zero on the next edge, in_allowin=1 the cycle after deassert; counter_clr pulse coinciding with out_fire -> retire_cnt=0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// N-stage valid/allowin pipeline controller with payload registers, per-stage
// flush and ready-go stalls, an output handshake, occupancy and perf counters.
module pipe_stage_chain #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 32,
    localparam int OCC_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_allowin,
    input  logic [NUM_STAGES-1:0]        stage_readygo,
    input  logic [NUM_STAGES-1:0]        flush,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic [OCC_W-1:0]             occupancy,
    input  logic                         counter_clr,
    output logic [CNT_W-1:0]             retire_cnt,
    output logic [CNT_W-1:0]             stall_cnt
);

    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_STAGES-1:0][DATA_W-1:0] up_data;
    logic [NUM_STAGES-1:0]             go;
    logic [NUM_STAGES-1:0]             up_go;
    logic [NUM_STAGES:0]               allowin;
    logic [CNT_W-1:0]                  retire_q, stall_q;
    logic                              out_fire;

    assign go      = valid_q & stage_readygo & ~flush;
    assign up_go   = {go[NUM_STAGES-2:0], in_valid};
    assign up_data = {data_q[NUM_STAGES-2:0], in_data};

    // Back-pressure ripples from the consumer toward stage 0; flush is
    // deliberately kept out of this chain so it never reaches in_allowin.
    always_comb begin
        allowin = '0;
        allowin[NUM_STAGES] = out_ready;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            allowin[i] = ~valid_q[i] | (stage_readygo[i] & allowin[i+1]);
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (allowin[i]) begin
                valid_d[i] = up_go[i];
            end
            if (allowin[i] && up_go[i] && !flush[i]) begin
                data_d[i] = up_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = go[NUM_STAGES-1];
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || counter_clr) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            if (out_fire) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (out_valid && !out_ready) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign in_allowin  = allowin[0] & ~reset;
    assign out_data    = data_q[NUM_STAGES-1];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign retire_cnt  = retire_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: table-driven streaming vectors plus
// hand sequences for stall, flush and reset corner cases.
module tb_pipe_stage_chain;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int CW = 32;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_allowin;
    logic [NS-1:0]  stage_readygo;
    logic [NS-1:0]  flush;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready;
    logic [NS-1:0]  stage_valid;
    logic [NS*DW-1:0] stage_data;
    logic [2:0]     occupancy;
    logic           counter_clr;
    logic [CW-1:0]  retire_cnt;
    logic [CW-1:0]  stall_cnt;

    pipe_stage_chain #(.NUM_STAGES(NS), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_allowin(in_allowin), .stage_readygo(stage_readygo), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy),
        .counter_clr(counter_clr), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        clr;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ia;
        logic [2:0]  e_occ;
        logic        chk_cnt;
        logic [31:0] e_ret;
        logic [31:0] e_stl;
    } vec_t;

    vec_t tbl[$];
    logic [31:0] got[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t row(input logic iv, input int id, input logic ordy,
                                 input logic clr, input logic e_ov, input int e_od,
                                 input logic e_ia, input int e_occ, input logic chk_cnt,
                                 input int e_ret, input int e_stl);
        vec_t r;
        r.iv = iv; r.id = 32'(id); r.ordy = ordy; r.clr = clr;
        r.e_ov = e_ov; r.e_od = 32'(e_od); r.e_ia = e_ia; r.e_occ = 3'(e_occ);
        r.chk_cnt = chk_cnt; r.e_ret = 32'(e_ret); r.e_stl = 32'(e_stl);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input int id, input logic [3:0] rg,
                         input logic [3:0] fl, input logic ordy, input logic clr);
        in_valid = iv; in_data = 32'(id); stage_readygo = rg;
        flush = fl; out_ready = ordy; counter_clr = clr;
    endtask

    task automatic fill4();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, k, 4'hF, 4'h0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 99, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("rst_allowin", in_allowin, 0);
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("rst_occ", occupancy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_sdata", stage_data, 0);
        chk("rst_ret", retire_cnt, 0);
        chk("rst_allowin_after", in_allowin, 1);

        // Streaming 1..8 at full rate, then back-pressure with 1..6.
        for (int k = 0; k < 8; k++)
            tbl.push_back(row(1, k + 1, 1, 0, k >= 4, k - 3, 1, (k <= 4) ? k : 4, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 5, 1, 4, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 6, 1, 3, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 7, 1, 2, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 8, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 1, 0, 0, 1, 0, 1, 8, 0));
        tbl.push_back(row(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(row(1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(row(1, 3, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(row(1, 4, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(row(1, 5, 0, 0, 1, 1, 0, 4, 0, 0, 0));
        tbl.push_back(row(1, 5, 0, 0, 1, 1, 0, 4, 0, 0, 0));
        tbl.push_back(row(1, 5, 0, 0, 1, 1, 0, 4, 0, 0, 0));
        tbl.push_back(row(1, 5, 1, 0, 1, 1, 1, 4, 0, 0, 0));
        tbl.push_back(row(1, 6, 1, 0, 1, 2, 1, 4, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 3, 1, 4, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 4, 1, 3, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 5, 1, 2, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 1, 6, 1, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 1, 0, 0, 0, 1, 0, 1, 6, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, int'(tbl[i].id), 4'hF, 4'h0, tbl[i].ordy, tbl[i].clr);
            #1;
            chk($sformatf("row%0d_ia", i), in_allowin, tbl[i].e_ia);
            chk($sformatf("row%0d_ov", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("row%0d_od", i), out_data, tbl[i].e_od);
            chk($sformatf("row%0d_occ", i), occupancy, tbl[i].e_occ);
            if (tbl[i].chk_cnt) begin
                chk($sformatf("row%0d_ret", i), retire_cnt, tbl[i].e_ret);
                chk($sformatf("row%0d_stl", i), stall_cnt, tbl[i].e_stl);
            end
            tick();
        end

        // Stage 1 stalls: stages 0-1 hold 4,3 while 2,1 drain.
        fill4();
        got.delete();
        drive(1'b0, 0, 4'b1101, 4'h0, 1'b1, 1'b0);
        #1;
        chk("st_a_ia", in_allowin, 0);
        chk("st_a_od", out_data, 1);
        tick();
        #1;
        chk("st_b_od", out_data, 2);
        chk("st_b_occ", occupancy, 3);
        chk("st_b_ia", in_allowin, 0);
        tick();
        #1;
        chk("st_c_ov", out_valid, 0);
        chk("st_c_occ", occupancy, 2);
        chk("st_c_s1", stage_data[63:32], 3);
        chk("st_c_s0", stage_data[31:0], 4);
        tick();
        stage_readygo = 4'hF;
        #1;
        chk("st_rel_ia", in_allowin, 1);
        for (int k = 0; k < 6; k++) tick();
        chk("st_cnt", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("st_order%0d", k), got[k], k + 1);

        // Flush of the two youngest stages while full.
        got.delete();
        drive(1'b1, 1, 4'hF, 4'h0, 1'b0, 1'b1);
        tick();
        for (int k = 2; k <= 4; k++) begin
            drive(1'b1, k, 4'hF, 4'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 4'hF, 4'b0011, 1'b1, 1'b0);
        #1;
        chk("fl_ov", out_valid, 1);
        chk("fl_od", out_data, 1);
        chk("fl_ia", in_allowin, 1);
        tick();
        drive(1'b1, 9, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("fl_occ", occupancy, 1);
        chk("fl_od2", out_data, 2);
        tick();
        drive(1'b0, 0, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("fl_ret2", retire_cnt, 2);
        for (int k = 0; k < 5; k++) tick();
        chk("fl_ret3", retire_cnt, 3);
        chk("fl_cnt", got.size(), 3);
        if (got.size() == 3) begin
            chk("fl_seq0", got[0], 1);
            chk("fl_seq1", got[1], 2);
            chk("fl_seq2", got[2], 9);
        end

        // Flush everything while full with a producer waiting.
        got.delete();
        fill4();
        drive(1'b1, 77, 4'hF, 4'hF, 1'b1, 1'b0);
        #1;
        chk("fa_ov", out_valid, 0);
        chk("fa_ia", in_allowin, 1);
        tick();
        drive(1'b0, 0, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("fa_occ", occupancy, 0);
        tick();

        // Item 5 moves from stage 1 into a flushed stage 2.
        drive(1'b1, 5, 4'hF, 4'h0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("f5_sv", stage_valid, 4'b0010);
        flush = 4'b0100;
        tick();
        flush = 4'h0;
        #1;
        chk("f5_sv_after", stage_valid, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("f5_none", got.size(), 0);
        chk("f5_ret", retire_cnt, 3);

        // Reset mid-stream, then counter clear coinciding with a retire.
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, k, 4'hF, 4'h0, 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("rs_occ3", occupancy, 3);
        reset = 1'b1;
        drive(1'b1, 7, 4'hF, 4'h0, 1'b1, 1'b0);
        #1;
        chk("rs_ia", in_allowin, 0);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rs_occ", occupancy, 0);
        chk("rs_ov", out_valid, 0);
        chk("rs_od", out_data, 0);
        chk("rs_sdata", stage_data, 0);
        chk("rs_ret", retire_cnt, 0);
        chk("rs_stl", stall_cnt, 0);
        chk("rs_ia_after", in_allowin, 1);
        got.delete();
        drive(1'b1, 42, 4'hF, 4'h0, 1'b1, 1'b0);
        tick();
        in_data = 43;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("cc_ov", out_valid, 1);
        chk("cc_od", out_data, 42);
        tick();
        counter_clr = 1'b1;
        #1;
        chk("cc_od2", out_data, 43);
        chk("cc_ret1", retire_cnt, 1);
        tick();
        counter_clr = 1'b0;
        #1;
        chk("cc_ret0", retire_cnt, 0);
        chk("cc_got", got.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
